// File: rtl/multi_txn_pkg.sv
// -----------------------------------------------------------------------------
// multi_txn_pkg
// Shared types and constants for the multi-cycle unit adapter.
//   state_e          : adapter control states (HOLD only used without the
//                      result buffer)
//   DEFAULT_LATENCY  : default compute latency of the multi-cycle unit
//   FIFO_DEPTH       : entries in the optional result FIFO
//   FIFO_CNT_W/PTR_W : derived FIFO occupancy / pointer widths
// -----------------------------------------------------------------------------
package multi_txn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DEFAULT_LATENCY = 4;
  localparam int FIFO_DEPTH      = 2;
  localparam int FIFO_CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W      = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/multi_txn_if.sv
// -----------------------------------------------------------------------------
// multi_txn_if
// Bundles the request stream, the multi-cycle unit drive and the response
// stream of the adapter.
//   slave  : adapter view (consumes requests, drives core, produces responses)
//   master : environment view (request source, core model, response sink)
// Signals: in_valid/in_ready/in_data, core_start/core_inp/core_out,
//          out_valid/out_ready/out_data.
// -----------------------------------------------------------------------------
interface multi_txn_if #(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             core_start;
  logic [WIDTH-1:0] core_inp;
  logic [WIDTH-1:0] core_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, core_out, out_ready,
    output in_ready, core_start, core_inp, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, core_out, out_ready,
    input  in_ready, core_start, core_inp, out_valid, out_data
  );

endinterface

// File: rtl/multi_txn_fifo.sv
// -----------------------------------------------------------------------------
// multi_txn_fifo
// Small result FIFO (FIFO_DEPTH entries) used by the adapter when the result
// buffer is enabled. Push and pop in the same cycle are both honoured.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   push/push_data : write request and data
//   pop            : read request (head is consumed)
//   count          : current occupancy
//   head           : oldest entry (zero after reset)
// -----------------------------------------------------------------------------
module multi_txn_fifo
  import multi_txn_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [WIDTH-1:0]      head
);

  logic [WIDTH-1:0]      mem_r [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_r;
  logic [FIFO_PTR_W-1:0] rd_ptr_r;
  logic [FIFO_CNT_W-1:0] count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop_s  = pop && (count_r != FIFO_CNT_W'(0));
  assign do_push_s = push && ((count_r != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= FIFO_PTR_W'(0);
      rd_ptr_r <= FIFO_PTR_W'(0);
      count_r  <= FIFO_CNT_W'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + FIFO_PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + FIFO_CNT_W'(1);
        2'b01:   count_r <= count_r - FIFO_CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/multi_txn_adapter.sv
// -----------------------------------------------------------------------------
// multi_txn_adapter
// Converts a valid/ready request stream into start/inp drive for a multi-cycle
// unit without a done flag, counts LATENCY cycles, captures the unit's result
// and offers it on a valid/ready response stream. At most one operation is in
// flight.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (drops any in-flight operation)
//   bus     : multi_txn_if.slave (request, core drive, response signals)
// Build option:
//   MULTI_TXN_RESULT_BUF_EN : replaces the single result register / HOLD
//                             state with a 2-entry result FIFO so a new
//                             operation may start while results wait.
// -----------------------------------------------------------------------------
module multi_txn_adapter
  import multi_txn_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input logic        clock,
  input logic        reset_n,
  multi_txn_if.slave bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

`ifdef MULTI_TXN_RESULT_BUF_EN
  localparam state_e CAPTURE_NEXT = IDLE;
`else
  localparam state_e CAPTURE_NEXT = HOLD;
`endif

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             in_ready_r, in_ready_s;
  logic             core_start_r;
  logic [WIDTH-1:0] core_inp_r;
  logic             accept_s;
  logic             capture_s;
  logic             room_s;
  logic             resp_fire_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] out_data_s;

  assign accept_s    = bus.in_valid && in_ready_r;
  // Counter holds LATENCY in the start cycle, so value 1 marks the last
  // cycle before out becomes usable downstream: sample core_out at that edge.
  assign capture_s   = (state_r == BUSY) && (cnt_r == CNT_W'(1));
  assign resp_fire_s = out_valid_s && bus.out_ready;

  // Next-state, counter and request-ready decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = BUSY;
          cnt_s   = CNT_W'(LATENCY);
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // Reaches 0 on the capture edge and is reloaded on the next accept.
        cnt_s = cnt_r - CNT_W'(1);
        if (capture_s) begin
          state_s = CAPTURE_NEXT;
        end else begin
          state_s = BUSY;
        end
      end
      HOLD: begin
        if (resp_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_W'(0);
      end
    endcase
    // Registered ready: a request is never taken in the cycle a response leaves.
    in_ready_s = (state_s == IDLE) && room_s;
  end

  // Control state, counter and core drive registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_W'(0);
      in_ready_r   <= 1'b0;
      core_start_r <= 1'b0;
      core_inp_r   <= {WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      in_ready_r   <= in_ready_s;
      core_start_r <= accept_s;
      if (accept_s) begin
        core_inp_r <= bus.in_data;
      end
    end
  end

`ifdef MULTI_TXN_RESULT_BUF_EN
  logic [FIFO_CNT_W-1:0] fifo_cnt_s;

  multi_txn_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (capture_s),
    .push_data (bus.core_out),
    .pop       (resp_fire_s),
    .count     (fifo_cnt_s),
    .head      (out_data_s)
  );

  assign out_valid_s = (fifo_cnt_s != FIFO_CNT_W'(0));
  // Room is judged on next cycle's occupancy to match the registered ready.
  assign room_s = (fifo_cnt_s + FIFO_CNT_W'(capture_s) - FIFO_CNT_W'(resp_fire_s))
                  < FIFO_CNT_W'(FIFO_DEPTH);
`else
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  // Single result register: loaded at capture, released on response handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= bus.core_out;
    end else if (resp_fire_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid_s = out_valid_r;
  assign out_data_s  = out_data_r;
  assign room_s      = 1'b1;
`endif

  assign bus.in_ready   = in_ready_r;
  assign bus.core_start = core_start_r;
  assign bus.core_inp   = core_inp_r;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = out_data_s;

endmodule

// File: tb/tb_multi_txn_adapter.sv
// -----------------------------------------------------------------------------
// tb_multi_txn_adapter
// Self-checking bench for multi_txn_adapter. Two instances: LATENCY=4 (main)
// and LATENCY=1 (boundary). Each drives a behavioural multi-cycle unit whose
// result is f(x) = x ^ 64'hAAAA_0000_BBBB_0000 and becomes valid LATENCY-1
// cycles after the start cycle (garbage before that).
// -----------------------------------------------------------------------------
module tb_multi_txn_adapter;
  import multi_txn_pkg::*;

  localparam int W  = 64;
  localparam int LA = 4;
  localparam int LB = 1;
  localparam logic [63:0] GARB = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] KEY  = 64'hAAAA_0000_BBBB_0000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  int   cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multi_txn_if #(.WIDTH(W)) bus_a ();
  multi_txn_if #(.WIDTH(W)) bus_b ();

  multi_txn_adapter #(.WIDTH(W), .LATENCY(LA)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  multi_txn_adapter #(.WIDTH(W), .LATENCY(LB)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  function automatic logic [63:0] unit_fn(input logic [63:0] x);
    return x ^ KEY;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Multi-cycle unit models: age counts cycles since the start cycle.
  logic [63:0] ma_inp = 64'd0, mb_inp = 64'd0;
  int          ma_age = 0,     mb_age = 0;

  always @(posedge clock) begin
    if (bus_a.core_start) begin ma_inp <= bus_a.core_inp; ma_age <= 1; end
    else if (ma_age != 0) ma_age <= ma_age + 1;
    if (bus_b.core_start) begin mb_inp <= bus_b.core_inp; mb_age <= 1; end
    else if (mb_age != 0) mb_age <= mb_age + 1;
  end

  always_comb begin
    if (bus_a.core_start) bus_a.core_out = (LA == 1) ? unit_fn(bus_a.core_inp) : GARB;
    else if (ma_age != 0 && ma_age >= LA - 1) bus_a.core_out = unit_fn(ma_inp);
    else bus_a.core_out = GARB;
    if (bus_b.core_start) bus_b.core_out = (LB == 1) ? unit_fn(bus_b.core_inp) : GARB;
    else if (mb_age != 0 && mb_age >= LB - 1) bus_b.core_out = unit_fn(mb_inp);
    else bus_b.core_out = GARB;
  end

  // Event logs: start cycles, out_valid rise cycles, accepted response data.
  int          sa_q[$], ra_q[$], sb_q[$], rb_q[$];
  logic [63:0] da_q[$], db_q[$];
  logic        pva = 1'b0, pvb = 1'b0;

  always @(negedge clock) begin
    if (bus_a.core_start) sa_q.push_back(cyc);
    if (bus_a.out_valid && !pva) ra_q.push_back(cyc);
    if (bus_a.out_valid && bus_a.out_ready) da_q.push_back(bus_a.out_data);
    pva <= bus_a.out_valid;
    if (bus_b.core_start) sb_q.push_back(cyc);
    if (bus_b.out_valid && !pvb) rb_q.push_back(cyc);
    if (bus_b.out_valid && bus_b.out_ready) db_q.push_back(bus_b.out_data);
    pvb <= bus_b.out_valid;
  end

  logic [63:0] req_q[$];

  task automatic clear_logs();
    sa_q.delete(); ra_q.delete(); da_q.delete();
    sb_q.delete(); rb_q.delete(); db_q.delete();
  endtask

  // Presents req_q on dut_a back-to-back; called and returns at a negedge.
  task automatic drive_a(input int budget);
    int idx = 0;
    bit acc;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = req_q[0];
    for (int c = 0; c < budget && idx < req_q.size(); c++) begin
      acc = bus_a.in_ready;
      @(negedge clock);
      if (acc) begin
        idx++;
        if (idx < req_q.size()) bus_a.in_data = req_q[idx];
        else bus_a.in_valid = 1'b0;
      end
    end
    bus_a.in_valid = 1'b0;
    checks++;
    if (idx != req_q.size()) begin
      errors++;
      $display("FAIL drive_a accepted=%0d required=%0d", idx, req_q.size());
    end
  endtask

  task automatic wait_resp_a(input int n, input int budget);
    for (int c = 0; c < budget && da_q.size() < n; c++) @(negedge clock);
    repeat (2) @(negedge clock);
    checks++;
    if (da_q.size() != n) begin
      errors++;
      $display("FAIL resp_count_a got=%0d required=%0d", da_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bus_a.in_valid = 1'b0; bus_a.in_data = 64'd0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 64'd0; bus_b.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b req=0", bus_a.in_ready); end
    checks++; if (bus_a.core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start got=%b req=0", bus_a.core_start); end
    checks++; if (bus_a.core_inp !== 64'd0) begin errors++; $display("FAIL rst_core_inp got=%h req=0", bus_a.core_inp); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b req=0", bus_a.out_valid); end
    checks++; if (bus_a.out_data !== 64'd0) begin errors++; $display("FAIL rst_out_data got=%h req=0", bus_a.out_data); end
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready_a got=%b req=1", bus_a.in_ready); end
    checks++; if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready_b got=%b req=1", bus_b.in_ready); end
  endtask

  task automatic test_single();
    clear_logs();
    bus_a.out_ready = 1'b1;
    req_q = {64'h0000_0001_0000_0002};
    drive_a(20);
    wait_resp_a(1, 30);
    checks++; if (sa_q.size() != 1) begin errors++; $display("FAIL single_start_cycles got=%0d req=1", sa_q.size()); end
    checks++;
    if (sa_q.size() < 1 || ra_q.size() != 1 || ra_q[0] != sa_q[0] + LA) begin
      errors++; $display("FAIL single_valid_cycle starts=%0d rises=%0d req_offset=%0d", sa_q.size(), ra_q.size(), LA);
    end
    checks++;
    if (da_q.size() < 1 || da_q[0] !== 64'hAAAA_0001_BBBB_0002) begin
      errors++; $display("FAIL single_data got=%h req=%h", (da_q.size() > 0) ? da_q[0] : 64'd0, 64'hAAAA_0001_BBBB_0002);
    end
  endtask

  task automatic test_stall();
    logic [63:0] d1, d2;
    int          c;
    clear_logs();
    d1 = rnd64(); d2 = rnd64();
    bus_a.out_ready = 1'b0;
    req_q = {d1};
    drive_a(20);
    bus_a.in_valid = 1'b1; bus_a.in_data = d2;
    for (c = 0; c < 20 && !bus_a.out_valid; c++) @(negedge clock);
    checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got=%b req=1", bus_a.out_valid); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (bus_a.out_data !== unit_fn(d1)) begin errors++; $display("FAIL stall_out_data cyc=%0d got=%h req=%h", k, bus_a.out_data, unit_fn(d1)); end
      checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b req=0", k, bus_a.in_ready); end
      @(negedge clock);
    end
    checks++; if (sa_q.size() != 1) begin errors++; $display("FAIL stall_starts got=%0d req=1", sa_q.size()); end
    bus_a.out_ready = 1'b1;
    req_q = {d2};
    drive_a(30);
    wait_resp_a(2, 40);
    checks++; if (sa_q.size() != 2) begin errors++; $display("FAIL stall_starts_after got=%0d req=2", sa_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (da_q.size() <= i || da_q[i] !== unit_fn(i == 0 ? d1 : d2)) begin
        errors++; $display("FAIL stall_order idx=%0d got=%h req=%h", i, (da_q.size() > i) ? da_q[i] : 64'd0, unit_fn(i == 0 ? d1 : d2));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    bus_a.out_ready = 1'b1;
    req_q = {rnd64(), rnd64(), rnd64()};
    drive_a(100);
    wait_resp_a(3, 100);
    checks++; if (sa_q.size() != 3) begin errors++; $display("FAIL b2b_starts got=%0d req=3", sa_q.size()); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (sa_q.size() <= i || sa_q[i] - sa_q[i-1] != LA + 2) begin
        errors++; $display("FAIL b2b_spacing idx=%0d got=%0d req=%0d", i, (sa_q.size() > i) ? sa_q[i] - sa_q[i-1] : -1, LA + 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (da_q.size() <= i || da_q[i] !== unit_fn(req_q[i])) begin
        errors++; $display("FAIL b2b_data idx=%0d got=%h req=%h", i, (da_q.size() > i) ? da_q[i] : 64'd0, unit_fn(req_q[i]));
      end
    end
  endtask

  task automatic test_buffer();
    logic [63:0] r0, r1, r2;
    clear_logs();
    r0 = rnd64(); r1 = rnd64(); r2 = rnd64();
    bus_a.out_ready = 1'b0;
    req_q = {r0, r1};
    drive_a(50);
    bus_a.in_valid = 1'b1; bus_a.in_data = r2;
    repeat (LA + 3) @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL buf_full_in_ready cyc=%0d got=%b req=0", k, bus_a.in_ready); end
      checks++; if (bus_a.out_data !== unit_fn(r0)) begin errors++; $display("FAIL buf_head cyc=%0d got=%h req=%h", k, bus_a.out_data, unit_fn(r0)); end
      @(negedge clock);
    end
    checks++; if (sa_q.size() != 2) begin errors++; $display("FAIL buf_starts got=%0d req=2", sa_q.size()); end
    bus_a.out_ready = 1'b1;
    req_q = {r2};
    drive_a(50);
    wait_resp_a(3, 50);
    checks++; if (sa_q.size() != 3) begin errors++; $display("FAIL buf_starts_after got=%0d req=3", sa_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (da_q.size() <= i || da_q[i] !== unit_fn(i == 0 ? r0 : (i == 1 ? r1 : r2))) begin
        errors++; $display("FAIL buf_order idx=%0d got=%h", i, (da_q.size() > i) ? da_q[i] : 64'd0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    clear_logs();
    bus_a.out_ready = 1'b1;
    req_q = {rnd64()};
    drive_a(20);                 // returns in the start cycle (counter=LA)
    repeat (2) @(negedge clock); // counter now 2
    reset_n = 1'b0;
    #1;
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%b req=0", bus_a.in_ready); end
    checks++; if (bus_a.core_start !== 1'b0) begin errors++; $display("FAIL mid_rst_core_start got=%b req=0", bus_a.core_start); end
    checks++; if (bus_a.core_inp !== 64'd0) begin errors++; $display("FAIL mid_rst_core_inp got=%h req=0", bus_a.core_inp); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b req=0", bus_a.out_valid); end
    checks++; if (bus_a.out_data !== 64'd0) begin errors++; $display("FAIL mid_rst_out_data got=%h req=0", bus_a.out_data); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (LA + 6) @(negedge clock);
    checks++; if (ra_q.size() != 0 || da_q.size() != 0) begin errors++; $display("FAIL mid_rst_ghost_resp rises=%0d resps=%0d req=0", ra_q.size(), da_q.size()); end
    clear_logs();
    d = rnd64();
    req_q = {d};
    drive_a(20);
    wait_resp_a(1, 30);
    checks++;
    if (sa_q.size() != 1 || ra_q.size() != 1 || ra_q[0] != sa_q[0] + LA) begin
      errors++; $display("FAIL mid_rst_next_timing starts=%0d rises=%0d req_offset=%0d", sa_q.size(), ra_q.size(), LA);
    end
    checks++;
    if (da_q.size() < 1 || da_q[0] !== unit_fn(d)) begin
      errors++; $display("FAIL mid_rst_next_data got=%h req=%h", (da_q.size() > 0) ? da_q[0] : 64'd0, unit_fn(d));
    end
  endtask

  task automatic test_latency1();
    logic [63:0] d;
    bit          done;
    for (int op = 0; op < 2; op++) begin
      clear_logs();
      d = rnd64();
      bus_b.out_ready = 1'b1;
      bus_b.in_valid  = 1'b1;
      bus_b.in_data   = d;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        done = bus_b.in_ready;
        @(negedge clock);
      end
      bus_b.in_valid = 1'b0;
      for (int c = 0; c < 20 && db_q.size() < 1; c++) @(negedge clock);
      repeat (2) @(negedge clock);
      checks++; if (sb_q.size() != 1) begin errors++; $display("FAIL lat1_starts op=%0d got=%0d req=1", op, sb_q.size()); end
      checks++;
      if (sb_q.size() < 1 || rb_q.size() != 1 || rb_q[0] != sb_q[0] + 1) begin
        errors++; $display("FAIL lat1_valid_cycle op=%0d starts=%0d rises=%0d req_offset=1", op, sb_q.size(), rb_q.size());
      end
      checks++;
      if (db_q.size() < 1 || db_q[0] !== unit_fn(d)) begin
        errors++; $display("FAIL lat1_data op=%0d got=%h req=%h", op, (db_q.size() > 0) ? db_q[0] : 64'd0, unit_fn(d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef MULTI_TXN_RESULT_BUF_EN
    test_buffer();
`else
    test_stall();
    test_back_to_back();
`endif
    test_reset_mid();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
